// File: rtl/abcd_array_seq.sv
// abcd_array_seq: command sequencer for a linear systolic chain of
// processor_ABCD elements. It accepts one {op, row count} command, streams
// that many operands from a synchronous-read buffer into the head of the chain
// framed by start/finish, holds the op code while the chain drains, and then
// pulses done (with err for a rejected command).
// Optional feature: define ABCD_SEQ_CYCLE_CNT_EN to add the 16-bit cycle_cnt
// output, which counts busy cycles of the most recent command.
module abcd_array_seq #(
  parameter int GF_BIT      = 4,
  parameter int OP_CODE_LEN = 4,
  parameter int LEN_W       = 7,
  parameter int PIPE_LAT    = 66
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OP_CODE_LEN-1:0] cmd_op,
  input  logic [LEN_W-1:0]       cmd_len,
  output logic                   rd_en,
  output logic [LEN_W-1:0]       rd_addr,
  input  logic [GF_BIT-1:0]      rd_data,
  output logic [OP_CODE_LEN-1:0] op_out,
  output logic [1:0]             gauss_op_out,
  output logic                   start_out,
  output logic                   finish_out,
  output logic [GF_BIT-1:0]      data_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
`ifdef ABCD_SEQ_CYCLE_CNT_EN
  ,
  output logic [15:0]            cycle_cnt
`endif
);

  localparam int DRAIN_W = $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAST,
    DRAIN,
    DONE
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [OP_CODE_LEN-1:0] op_lat;
  logic [LEN_W-1:0]       len_lat;
  logic                   err_lat;
  logic [LEN_W-1:0]       addr;
  logic [DRAIN_W-1:0]     drain_cnt;
  logic                   accept;
  logic                   cmd_bad;
  logic                   last_addr;
  logic                   hold_op;

  logic                   beat_q;
  logic                   start_q;
  logic                   finish_q;
  logic [OP_CODE_LEN-1:0] op_q;
  logic [1:0]             gauss_q;

  // Only these op codes are understood by the processor chain.
  function automatic logic op_legal(input logic [OP_CODE_LEN-1:0] op);
    return (op == OP_CODE_LEN'(1)) || (op == OP_CODE_LEN'(3)) ||
           (op == OP_CODE_LEN'(4)) || (op == OP_CODE_LEN'(5)) ||
           (op == OP_CODE_LEN'(6)) || (op == OP_CODE_LEN'(8)) ||
           (op == OP_CODE_LEN'(9));
  endfunction

  // Ops 1 and 4 run the chain in elimination mode; everything else uses 2'b00.
  function automatic logic [1:0] gauss_map(input logic [OP_CODE_LEN-1:0] op);
    return ((op == OP_CODE_LEN'(1)) || (op == OP_CODE_LEN'(4))) ? 2'b11 : 2'b00;
  endfunction

  assign accept    = cmd_valid && (state == IDLE);
  assign cmd_bad   = !op_legal(cmd_op) || (cmd_len == '0);
  assign last_addr = (addr == len_lat - LEN_W'(1));

  // Next-state decode and the state-derived handshake/read outputs.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    rd_en      = 1'b0;
    rd_addr    = '0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (accept) next_state = cmd_bad ? DONE : READ;
      end
      READ: begin
        rd_en   = 1'b1;
        rd_addr = addr;
        if (last_addr) next_state = LAST;
      end
      LAST: next_state = DRAIN;
      DRAIN: begin
        if (drain_cnt == DRAIN_W'(PIPE_LAT - 1)) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        err        = err_lat;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Command latch, read address counter and drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_lat    <= '0;
      len_lat   <= '0;
      err_lat   <= 1'b0;
      addr      <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        op_lat  <= cmd_op;
        len_lat <= cmd_len;
        err_lat <= cmd_bad;
        addr    <= '0;
      end else if (state == READ && !last_addr) begin
        addr <= addr + LEN_W'(1);
      end
      if (state == LAST)       drain_cnt <= '0;
      else if (state == DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

  // The op code stays on the chain through the final beat and the whole drain,
  // dropping to zero exactly when DONE is reached.
  assign hold_op = (state == READ) || (state == LAST) ||
                   ((state == DRAIN) && (next_state == DRAIN));

  // Chain-side output register, one cycle behind rd_en so it lines up with rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q   <= 1'b0;
      start_q  <= 1'b0;
      finish_q <= 1'b0;
      op_q     <= '0;
      gauss_q  <= 2'b00;
    end else begin
      beat_q   <= (state == READ);
      start_q  <= (state == READ) && (addr == '0);
      finish_q <= (state == READ) && last_addr;
      op_q     <= hold_op ? op_lat : '0;
      gauss_q  <= hold_op ? gauss_map(op_lat) : 2'b00;
    end
  end

  assign data_out     = beat_q ? rd_data : '0;
  assign start_out    = start_q;
  assign finish_out   = finish_q;
  assign op_out       = op_q;
  assign gauss_op_out = gauss_q;

`ifdef ABCD_SEQ_CYCLE_CNT_EN
  // Busy-cycle counter for the latest command, saturating, held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             cycle_cnt <= '0;
    else if (accept)                        cycle_cnt <= '0;
    else if (busy && cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
  end
`endif

endmodule
